calc_sequencer: RTL and testbench
=================================

// Module: calc_sequencer
// PURPOSE
//  Clocked operation sequencer for the 7-seg calculator datapath.
//  - Accepts a start request; latches A, B and op.
//  - Runs add/sub in one compute cycle, and mul/div/mod as WIDTH-step iterative shift-add / restoring-divide.
//  - Holds result, sign and err for the BCD/display path until the next accepted start.
//  - Replaces the combinational multiplier/divider with a start/busy/done handshake.
// PARAMETERS
//  WIDTH  8  operand width; result is 2*WIDTH bits; iteration count = WIDTH
// PORTS
//  clk     in   1         system clock, all state updates on rising edge
//  rst     in   1         reset, synchronous, active-high
//  start   in   1         request; sampled only in IDLE
//  A       in   WIDTH     operand A (unsigned)
//  B       in   WIDTH     operand B (unsigned)
//  op      in   3         0 add, 1 sub, 2 mul, 3 div, 4 mod, 5-7 invalid
//  busy    out  1         high in every state except IDLE
//  done    out  1         one-cycle pulse, high in DONE state
//  result  out  2*WIDTH   unsigned magnitude of last result
//  sign    out  1         1 = last sub result negative (result = B-A)
//  err     out  1         1 = last op was div/mod by zero or invalid op
//  res_op  out  3         op code belonging to held result (feeds display controller)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE.
//  - Outputs after reset: busy=0, done=0, result=0, sign=0, err=0, res_op=0.
//  - Internal operand, accumulator, remainder and step-counter registers are cleared.
//  - Reset overrides start and any in-flight iteration; aborted operations produce no done.
//  FSM states: IDLE, CALC, ITER, DONE.
//  IDLE: start=1 at edge -> latch A, B, op; then:
//  - op 0/1 -> CALC.
//  - op 2 -> ITER with step counter = 0.
//  - op 3/4 with B!=0 -> ITER with step counter = 0.
//  - op 3/4 with B==0, or op 5-7 -> CALC with error flag set.
//  CALC: one cycle, then -> DONE.
//  - add: result = A+B zero-extended (max 2*(2^WIDTH-1)); sign=0.
//  - sub: A>=B -> result = A-B, sign=0; A<B -> result = B-A, sign=1.
//  - error path: result = 0, sign=0, err=1.
//  ITER: exactly WIDTH cycles, counter 0..WIDTH-1; at counter==WIDTH-1 -> DONE.
//  - mul: LSB-first shift-add into 2*WIDTH accumulator; final value = A*B exactly.
//  - div/mod: MSB-first restoring divide with a WIDTH+1-bit partial remainder.
//    - quotient goes to result for op 3; remainder goes to result for op 4.
//    - both are zero-extended to 2*WIDTH.
//  DONE: one cycle, done=1 -> IDLE.
//  - result, sign, err and res_op load on the edge entering DONE.
//  - They stay stable until the edge entering DONE of the next operation.
//  - err=0 and sign=0 for mul/div/mod.
//  Latency: start sampled at edge 0.
//  - add, sub and error cases: done high in cycle 2.
//  - mul, div, mod: done high in cycle WIDTH+1 (cycle 9 at default).
//  Throughput: busy stays high through DONE.
//  - Next start is accepted no earlier than the edge after DONE.
//  - Minimum spacing between accepted starts: 3 cycles (add/sub), WIDTH+2 cycles (iterative).
//  start while busy (including the DONE cycle) is ignored and never queued.
//  A, B and op may change freely after acceptance; only latched copies are used.
// TESTING
//  add: A=200, B=100, op=0, start pulse -> done in cycle 2, result=300, sign=0, err=0, res_op=0.
//  sub: A=5, B=9, op=1 -> result=4, sign=1; then A=9, B=5 -> result=4, sign=0.
//  mul: A=255, B=255, op=2 -> busy for cycles 1-9, done in cycle 9, result=65025.
//  div/mod: A=200, B=7 -> op=3 result=28; op=4 result=4.
//    - A=7, B=0, op=3 -> err=1, result=0, done in cycle 2.
//  start re-asserted every cycle during mul (A=3, B=4) with other operands -> single result 12;
//    - the extra start in the DONE cycle is ignored.
//  rst=1 in cycle 4 of mul -> IDLE next cycle, all outputs 0, no done pulse;
//    - a new add then completes normally.

Source files
------------

// File: rtl/calc_sequencer.sv
// Start/busy/done operation sequencer for the calculator datapath: add/sub in one
// compute cycle, mul/div/mod as WIDTH-step shift-add / restoring-divide iterations.
module calc_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           op,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 sign,
    output logic                 err,
    output logic [2:0]           res_op,
    output logic [1:0]           fsm_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // Handshake: start is sampled only in IDLE; busy is high in every other state;
    // done pulses for the single DONE cycle, and requests during busy are dropped.
    state_t state, state_next;

    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [2:0]         op_reg;
    logic               err_flag;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH:0]     rem;
    logic [CW-1:0]      step;

    logic               start_iter, start_err;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [2*WIDTH-1:0] calc_result;
    logic               calc_sign;

    always_comb begin
        start_iter = (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && (B != '0));
        start_err  = !start_iter && (op != OP_ADD) && (op != OP_SUB);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = start_iter ? ITER : CALC;
            CALC: state_next = DONE;
            ITER: if (step == LAST_STEP) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        fsm_state = state;
    end

    // In mul, quo holds the multiplier shifting right; in div/mod it holds the
    // dividend shifting out MSB-first while quotient bits shift in from the right.
    always_comb begin
        acc_next = quo[0] ? (acc + mcand) : acc;
        shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, b_reg};
        if (!diff[WIDTH+1]) begin
            rem_next = diff[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted;
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        calc_result = '0;
        calc_sign   = 1'b0;
        if (!err_flag) begin
            if (op_reg == OP_ADD) begin
                calc_result = {{WIDTH{1'b0}}, a_reg} + {{WIDTH{1'b0}}, b_reg};
            end else if (a_reg >= b_reg) begin
                calc_result = {{WIDTH{1'b0}}, a_reg - b_reg};
            end else begin
                calc_result = {{WIDTH{1'b0}}, b_reg - a_reg};
                calc_sign   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= '0;
            err_flag <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            quo      <= '0;
            rem      <= '0;
            step     <= '0;
            result   <= '0;
            sign     <= 1'b0;
            err      <= 1'b0;
            res_op   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_reg    <= A;
                    b_reg    <= B;
                    op_reg   <= op;
                    err_flag <= start_err;
                    acc      <= '0;
                    mcand    <= {{WIDTH{1'b0}}, A};
                    quo      <= (op == OP_MUL) ? B : A;
                    rem      <= '0;
                    step     <= '0;
                end
                CALC: begin
                    result <= calc_result;
                    sign   <= calc_sign;
                    err    <= err_flag;
                    res_op <= op_reg;
                end
                ITER: begin
                    step <= step + 1'b1;
                    if (op_reg == OP_MUL) begin
                        acc   <= acc_next;
                        mcand <= mcand << 1;
                        quo   <= quo >> 1;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                    end
                    if (step == LAST_STEP) begin
                        if (op_reg == OP_MUL)      result <= acc_next;
                        else if (op_reg == OP_DIV) result <= {{WIDTH{1'b0}}, quo_next};
                        else                       result <= {{WIDTH{1'b0}}, rem_next[WIDTH-1:0]};
                        sign   <= 1'b0;
                        err    <= 1'b0;
                        res_op <= op_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized and directed bench for calc_sequencer; results are predicted with
// plain arithmetic and checked by a done-driven monitor against an expected queue.
module tb_calc_sequencer;

    localparam int W  = 8;
    localparam int EW = 3 + 1 + 1 + 2*W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic [2:0]     op = '0;
    logic           busy, done, sign, err;
    logic [2*W-1:0] result;
    logic [2:0]     res_op;
    logic [1:0]     fsm_state;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    calc_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .op(op),
        .busy(busy), .done(done), .result(result), .sign(sign), .err(err),
        .res_op(res_op), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference: result fields straight from the arithmetic definition of each op.
    function automatic logic [EW-1:0] model(input int a, input int b, input int o);
        int  res;
        logic s, e;
        res = 0; s = 1'b0; e = 1'b0;
        case (o)
            0: res = a + b;
            1: if (a >= b) res = a - b; else begin res = b - a; s = 1'b1; end
            2: res = a * b;
            3: if (b == 0) e = 1'b1; else res = a / b;
            4: if (b == 0) e = 1'b1; else res = a % b;
            default: e = 1'b1;
        endcase
        return {o[2:0], e, s, res[2*W-1:0]};
    endfunction

    function automatic int latency(input int b, input int o);
        if (o == 2 || ((o == 3 || o == 4) && b != 0)) return W + 1;
        return 2;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got result %0d with no expected entry at %0t", result, $time);
            end else begin
                chk("done_result", {res_op, err, sign, result}, exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input int a, input int b, input int o, input bit hammer);
        logic [EW-1:0] exp;
        int n, lat;
        exp = model(a, b, o);
        lat = latency(b, o);
        exp_q.push_back(exp);
        A = a[W-1:0]; B = b[W-1:0]; op = o[2:0]; start = 1'b1;
        @(posedge clk); #1;
        if (!hammer) start = 1'b0;
        A = $urandom; B = $urandom; op = 3'($urandom_range(0, 7));
        n = 1;
        while (!done && n < 40) begin
            chk("busy_during_op", busy, 1);
            if (hammer) begin
                A = $urandom; B = $urandom; op = 3'($urandom_range(0, 7));
            end
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, lat);
        chk("busy_in_done", busy, 1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_after_done", busy, 0);
        @(posedge clk); #1;
        chk("result_hold", {res_op, err, sign, result}, exp);
    endtask

    initial begin
        int ndone;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_sign", sign, 0);
        chk("rst_err", err, 0);
        chk("rst_res_op", res_op, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(200, 100, 0, 1'b0);
        do_op(5, 9, 1, 1'b0);
        do_op(9, 5, 1, 1'b0);
        do_op(255, 255, 2, 1'b0);
        do_op(200, 7, 3, 1'b0);
        do_op(200, 7, 4, 1'b0);
        do_op(7, 0, 3, 1'b0);
        do_op(7, 0, 4, 1'b0);
        do_op(12, 3, 6, 1'b0);
        do_op(255, 1, 3, 1'b0);
        do_op(0, 255, 4, 1'b0);
        do_op(3, 4, 2, 1'b1);
        do_op(20, 30, 1, 1'b1);

        // Abort a multiply mid-iteration: no done, all outputs cleared.
        A = 3; B = 4; op = 2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_sign", sign, 0);
        chk("abort_err", err, 0);
        chk("abort_res_op", res_op, 0);
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        do_op(17, 25, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int a, b, o;
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            o = $urandom_range(0, 7);
            do_op(a, b, o, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
